// File: rtl/panel_correct_offset_seq.sv
// Offset-correction sweep over coefficients 1,2,3,5,6,7: read, add programmed offset,
// clamp to 0..4095 and write back in place through a 3-stage pipeline.
module panel_correct_offset_seq #(
   parameter int AW   = 8,
   parameter int NPIX = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_start,
   input  logic          cmd_abort,
   output logic          cmd_busy,
   output logic          cmd_done,
   output logic          cmd_aborted,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_sel,
   input  logic [15:0]   cfg_offset,
   output logic          cfg_err,
   output logic          ram_re,
   output logic [AW+2:0] ram_raddr,
   input  logic [15:0]   ram_rdata,
   output logic          ram_we,
   output logic [AW+2:0] ram_waddr,
   output logic [15:0]   ram_wdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [2:0]      seq_q, seq_d;
   logic [1:0]      drain_q, drain_d;
   logic            aborted_q, aborted_d;
   logic            cfg_err_q, cfg_err_d;
   logic [11:0]     off_q [8];
   logic [11:0]     off_d [8];

   logic            p1_vld_q, p1_vld_d;
   logic [AW+2:0]   p1_addr_q, p1_addr_d;
   logic [11:0]     p1_off_q, p1_off_d;
   logic            p2_vld_q, p2_vld_d;
   logic [AW+2:0]   p2_addr_q, p2_addr_d;
   logic [13:0]     p2_sum_q, p2_sum_d;
   logic            p3_vld_q, p3_vld_d;
   logic [AW+2:0]   p3_addr_q, p3_addr_d;
   logic [11:0]     p3_res_q, p3_res_d;

   logic [2:0]      cur_coef;
   logic [AW+2:0]   rd_addr;
   logic            issue;
   logic            busy;

   // Sequence slot 0..5 maps onto coefficients 1,2,3,5,6,7 (skipping 4).
   assign cur_coef = seq_q + 3'd1 + ((seq_q >= 3'd3) ? 3'd1 : 3'd0);
   assign rd_addr  = {cur_coef, idx_q};
   assign issue    = (state_q == ST_RUN) && !cmd_abort;
   assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      seq_d     = seq_q;
      drain_d   = drain_q;
      aborted_d = aborted_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_start) begin
               state_d = ST_RUN;
               idx_d   = '0;
               seq_d   = 3'd0;
            end
         end
         ST_RUN: begin
            if (cmd_abort) begin
               // The abort cycle already counts as the first drain cycle.
               state_d   = ST_DRAIN;
               drain_d   = 2'd1;
               aborted_d = 1'b1;
            end else if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (seq_q == 3'd5) begin
                  state_d   = ST_DRAIN;
                  drain_d   = 2'd0;
                  aborted_d = 1'b0;
               end else begin
                  seq_d = seq_q + 3'd1;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == 2'd2) state_d = ST_DONE;
            else                 drain_d = drain_q + 2'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         off_d[i] = off_q[i];
      end
      if (cfg_we && !busy) off_d[cfg_sel] = cfg_offset[11:0];
      cfg_err_d = cfg_we && busy;
   end

   always_comb begin
      p1_vld_d  = issue;
      p1_addr_d = rd_addr;
      p1_off_d  = off_q[cur_coef];
      p2_vld_d  = p1_vld_q;
      p2_addr_d = p1_addr_q;
      p2_sum_d  = {ram_rdata[12], ram_rdata[12:0]} + {{2{p1_off_q[11]}}, p1_off_q};
      p3_vld_d  = p2_vld_q;
      p3_addr_d = p2_addr_q;
      case (p2_sum_q[13:12])
         2'b00:   p3_res_d = p2_sum_q[11:0];
         2'b01:   p3_res_d = 12'hFFF;
         default: p3_res_d = 12'h000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         seq_q     <= 3'd0;
         drain_q   <= 2'd0;
         aborted_q <= 1'b0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < 8; i++) off_q[i] <= 12'h000;
         p1_vld_q  <= 1'b0;
         p1_addr_q <= '0;
         p1_off_q  <= 12'h000;
         p2_vld_q  <= 1'b0;
         p2_addr_q <= '0;
         p2_sum_q  <= 14'h0000;
         p3_vld_q  <= 1'b0;
         p3_addr_q <= '0;
         p3_res_q  <= 12'h000;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         seq_q     <= seq_d;
         drain_q   <= drain_d;
         aborted_q <= aborted_d;
         cfg_err_q <= cfg_err_d;
         for (int i = 0; i < 8; i++) off_q[i] <= off_d[i];
         p1_vld_q  <= p1_vld_d;
         p1_addr_q <= p1_addr_d;
         p1_off_q  <= p1_off_d;
         p2_vld_q  <= p2_vld_d;
         p2_addr_q <= p2_addr_d;
         p2_sum_q  <= p2_sum_d;
         p3_vld_q  <= p3_vld_d;
         p3_addr_q <= p3_addr_d;
         p3_res_q  <= p3_res_d;
      end
   end

   assign cmd_busy    = busy;
   assign cmd_done    = (state_q == ST_DONE);
   assign cmd_aborted = aborted_q;
   assign cfg_err     = cfg_err_q;
   assign ram_re      = issue;
   assign ram_raddr   = issue ? rd_addr : '0;
   assign ram_we      = p3_vld_q;
   assign ram_waddr   = p3_addr_q;
   assign ram_wdata   = {4'd0, p3_res_q};

endmodule

// File: tb/tb_panel_correct_offset_seq.sv
// Bench for panel_correct_offset_seq: clamp vector table, abort/reset/back-to-back
// sequences and randomized sweeps against an arithmetic reference model.
module tb_panel_correct_offset_seq;
   localparam int AW   = 2;
   localparam int NPIX = 4;
   localparam int NRD  = 6 * NPIX;
   localparam int NMEM = 8 * NPIX;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_start, cmd_abort;
   logic          cmd_busy, cmd_done, cmd_aborted;
   logic          cfg_we;
   logic [2:0]    cfg_sel;
   logic [15:0]   cfg_offset;
   logic          cfg_err;
   logic          ram_re, ram_we;
   logic [AW+2:0] ram_raddr, ram_waddr;
   logic [15:0]   ram_rdata = 16'h0000;
   logic [15:0]   ram_wdata;

   always #5 clk = ~clk;

   panel_correct_offset_seq #(.AW(AW), .NPIX(NPIX)) dut (
      .clk(clk), .rst(rst),
      .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_aborted(cmd_aborted),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_offset(cfg_offset), .cfg_err(cfg_err),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
   );

   logic [15:0] mem [NMEM];
   logic [11:0] off_m [8];
   int          wr_log [NMEM];
   int          coefs [6] = '{1, 2, 3, 5, 6, 7};
   int          checks = 0;
   int          failures = 0;

   // Coefficient RAM contents are only loaded by the stimulus; writes are logged.
   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   typedef struct {
      int          coef;
      logic [15:0] rdata;
      logic [11:0] off;
      logic [11:0] expv;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, expv);
      end
   endtask

   // Signed 13-bit raw value plus signed 12-bit offset, saturated to 0..4095.
   function automatic int model(input logic [15:0] rd, input logic [11:0] off);
      int v, o, s;
      v = int'(rd[12:0]);
      if (v >= 4096) v -= 8192;
      o = int'(off);
      if (o >= 2048) o -= 4096;
      s = v + o;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      return s;
   endfunction

   function automatic int exp_addr(input int i);
      return coefs[i / NPIX] * NPIX + (i % NPIX);
   endfunction

   task automatic cfg_write(input int sel, input logic [15:0] val);
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_offset = val;
      @(negedge clk);
      cfg_we = 1'b0;
      #1 chk("cfg_err_idle", {31'd0, cfg_err}, 32'd0);
      off_m[sel] = val[11:0];
   endtask

   task automatic run_cmd(input int abort_k, input int cfg_k, input string name);
      int exp_a [NRD];
      int exp_d [NRD];
      int n_exp, exp_done, rd, wr, done_c, a;
      n_exp    = (abort_k > 0) ? abort_k - 1 : NRD;
      exp_done = (abort_k > 0) ? abort_k + 3 : NRD + 4;
      for (int i = 0; i < NRD; i++) begin
         a = exp_addr(i);
         exp_a[i] = a;
         exp_d[i] = model(mem[a], off_m[a / NPIX]);
      end
      for (int i = 0; i < NMEM; i++) wr_log[i] = -1;
      rd = 0; wr = 0; done_c = 0;
      @(negedge clk);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      for (int c = 1; c <= NRD + 20 && done_c == 0; c++) begin
         cmd_abort  = (c == abort_k);
         cfg_we     = (c == cfg_k);
         cfg_sel    = 3'd3;
         cfg_offset = 16'h07FF;
         #1;
         if (ram_re) begin
            if (rd < n_exp) begin
               chk({name, "_raddr"}, 32'(ram_raddr), 32'(exp_a[rd]));
               chk({name, "_rd_cycle"}, 32'(c), 32'(rd + 1));
            end else begin
               chk({name, "_rd_count"}, 32'(rd + 1), 32'(n_exp));
            end
            rd++;
         end
         if (ram_we) begin
            if (wr < n_exp) begin
               chk({name, "_waddr"}, 32'(ram_waddr), 32'(exp_a[wr]));
               chk({name, "_wdata"}, 32'(ram_wdata), 32'(exp_d[wr]));
               chk({name, "_wr_cycle"}, 32'(c), 32'(wr + 4));
            end else begin
               chk({name, "_wr_count"}, 32'(wr + 1), 32'(n_exp));
            end
            wr_log[ram_waddr] = int'(ram_wdata);
            wr++;
         end
         if (cfg_k > 0 && c == cfg_k + 1) chk({name, "_cfg_err"}, {31'd0, cfg_err}, 32'd1);
         chk({name, "_busy"}, {31'd0, cmd_busy}, (c < exp_done) ? 32'd1 : 32'd0);
         if (cmd_done) done_c = c;
         else @(negedge clk);
      end
      cmd_abort = 1'b0;
      cfg_we    = 1'b0;
      chk({name, "_done_cycle"}, 32'(done_c), 32'(exp_done));
      chk({name, "_reads"}, 32'(rd), 32'(n_exp));
      chk({name, "_writes"}, 32'(wr), 32'(n_exp));
      chk({name, "_aborted"}, {31'd0, cmd_aborted}, (abort_k > 0) ? 32'd1 : 32'd0);
      $display("run %s reads=%0d writes=%0d done_cycle=%0d aborted=%0b",
               name, rd, wr, done_c, cmd_aborted);
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_busy"},  {31'd0, cmd_busy}, 32'd0);
      chk({name, "_done"},  {31'd0, cmd_done}, 32'd0);
      chk({name, "_abtd"},  {31'd0, cmd_aborted}, 32'd0);
      chk({name, "_cerr"},  {31'd0, cfg_err}, 32'd0);
      chk({name, "_re"},    {31'd0, ram_re}, 32'd0);
      chk({name, "_we"},    {31'd0, ram_we}, 32'd0);
      chk({name, "_raddr"}, 32'(ram_raddr), 32'd0);
      chk({name, "_waddr"}, 32'(ram_waddr), 32'd0);
      chk({name, "_wdata"}, 32'(ram_wdata), 32'd0);
   endtask

   initial begin
      int ndone, rds, first_rd, done_at0, done_at1;
      rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
      cfg_we = 1'b0; cfg_sel = 3'd0; cfg_offset = 16'h0000;
      for (int i = 0; i < 8; i++) off_m[i] = 12'h000;
      for (int i = 0; i < NMEM; i++) mem[i] = 16'h0100;

      tbl[0] = '{1, 16'h0FF0, 12'h020, 12'hFFF};
      tbl[1] = '{2, 16'h0005, 12'hFF0, 12'h000};
      tbl[2] = '{3, 16'h1800, 12'h000, 12'h000};
      tbl[3] = '{5, 16'h0FFF, 12'h000, 12'hFFF};
      tbl[4] = '{6, 16'h0100, 12'h010, 12'h110};
      tbl[5] = '{7, 16'hFFFF, 12'h7FF, 12'h7FE};

      repeat (3) @(negedge clk);
      #1 check_idle_outputs("reset");
      rst = 1'b0;

      // Basic sweep
      cfg_write(1, 16'h0010);
      run_cmd(0, 0, "basic");

      // Clamp table
      foreach (tbl[r]) begin
         for (int i = 0; i < NPIX; i++) mem[tbl[r].coef * NPIX + i] = tbl[r].rdata;
         cfg_write(tbl[r].coef, {4'd0, tbl[r].off});
      end
      run_cmd(0, 0, "clamp");
      foreach (tbl[r]) begin
         for (int i = 0; i < NPIX; i++)
            chk("clamp_tbl", 32'(wr_log[tbl[r].coef * NPIX + i]), 32'(tbl[r].expv));
      end

      // Aborts
      for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
      run_cmd(6, 0, "abort6");
      run_cmd(1, 0, "abort1");

      // Reset in the middle of a sweep
      @(negedge clk);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1 check_idle_outputs("midrst");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) off_m[i] = 12'h000;
      repeat (4) begin
         @(negedge clk);
         #1 chk("midrst_no_wb", {31'd0, ram_we}, 32'd0);
      end
      run_cmd(0, 0, "post_reset");

      // Config while busy is dropped, while idle takes effect
      cfg_write(3, 16'h0010);
      run_cmd(0, 8, "cfg_busy");
      cfg_write(3, 16'h07FF);
      run_cmd(0, 0, "cfg_idle");

      // Back-to-back with start held high
      ndone = 0; rds = 0; first_rd = 0; done_at0 = 0; done_at1 = 0;
      @(negedge clk);
      cmd_start = 1'b1;
      for (int c = 1; c <= 100 && ndone < 2; c++) begin
         @(negedge clk);
         #1;
         if (ram_re) begin
            if (ndone == 1 && rds == 0) first_rd = c;
            rds++;
         end
         if (cmd_done) begin
            chk("b2b_reads", 32'(rds), 32'(NRD));
            rds = 0;
            ndone++;
            if (ndone == 1) done_at0 = c;
            else begin
               done_at1 = c;
               cmd_start = 1'b0;
            end
         end
      end
      cmd_start = 1'b0;
      chk("b2b_done0", 32'(done_at0), 32'(NRD + 4));
      chk("b2b_first_rd", 32'(first_rd), 32'(done_at0 + 2));
      chk("b2b_done1", 32'(done_at1), 32'(done_at0 + NRD + 5));
      repeat (2) @(negedge clk);
      #1 chk("b2b_stop", {31'd0, cmd_busy}, 32'd0);
      $display("run b2b done0=%0d first_rd2=%0d done1=%0d", done_at0, first_rd, done_at1);

      // Randomized sweeps
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
         for (int s = 0; s < 8; s++) cfg_write(s, 16'($urandom));
         run_cmd((r == 2) ? int'($urandom_range(2, NRD)) : 0, 0, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
